// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipe_vec family of pipeline blocks.
package pipe_pkg;

    localparam int MAX_ELASTIC_DEPTH = 16;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/elastic_stage.sv
// One valid+payload register of the elastic pipeline; loads from its source when advanced.
module elastic_stage #(
    parameter int DWIDTH    = 8,
    parameter int DataReset = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_flush,
    input  logic              i_adv,
    input  logic              i_src_valid,
    input  logic [DWIDTH-1:0] i_src_data,
    output logic              o_valid,
    output logic [DWIDTH-1:0] o_data
);

    logic              r_valid;
    logic [DWIDTH-1:0] r_data;
    logic              w_load;

    // Payload only toggles when a real word moves in; valid bits carry the bubbles.
    assign w_load = i_adv & i_src_valid & ~i_flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_adv) begin
            r_valid <= i_src_valid;
        end
    end

    generate
        if (DataReset != 0) begin : g_data_rst
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_data <= '0;
                end else if (w_load) begin
                    r_data <= i_src_data;
                end
            end
        end else begin : g_data_norst
            always_ff @(posedge clk) begin
                if (w_load) begin
                    r_data <= i_src_data;
                end
            end
        end
    endgenerate

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_vec_elastic.sv
// N-stage elastic pipeline with bubble squashing, synchronous flush and occupancy count.
module pipe_vec_elastic
    import pipe_pkg::*;
#(
    parameter int DWIDTH    = 8,
    parameter int N         = 2,
    parameter int DataReset = 0,
    localparam int CW       = cnt_w(N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DWIDTH-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DWIDTH-1:0] o_data,
    output logic [CW-1:0]     o_count
);

    // Handshake: a word moves across a port on any rising edge where valid and
    // ready are both high; a valid producer holds its payload until that edge.

    generate
        if (N < 1 || N > MAX_ELASTIC_DEPTH) begin : g_bad_depth
            $error("pipe_vec_elastic: N out of range");
        end
    endgenerate

    logic [N:0]        w_adv;
    logic [N-1:0]      w_v;
    logic [DWIDTH-1:0] w_d [N];
    logic              w_up;
    logic              w_dn;
    logic [CW-1:0]     r_count;

    // A stage may advance if it is empty or the stage ahead of it advances.
    always_comb begin : p_adv_chain
        logic w_chain;
        w_chain  = i_ready;
        w_adv[N] = w_chain;
        for (int k = N - 1; k >= 0; k--) begin
            w_chain  = ~w_v[k] | w_chain;
            w_adv[k] = w_chain;
        end
    end

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_stage
            logic              w_src_v;
            logic [DWIDTH-1:0] w_src_d;
            if (g == 0) begin : g_head
                assign w_src_v = i_valid;
                assign w_src_d = i_data;
            end else begin : g_body
                assign w_src_v = w_v[g-1];
                assign w_src_d = w_d[g-1];
            end
            elastic_stage #(
                .DWIDTH    (DWIDTH),
                .DataReset (DataReset)
            ) u_stage (
                .clk         (clk),
                .reset       (reset),
                .i_flush     (i_flush),
                .i_adv       (w_adv[g]),
                .i_src_valid (w_src_v),
                .i_src_data  (w_src_d),
                .o_valid     (w_v[g]),
                .o_data      (w_d[g])
            );
        end
    endgenerate

    assign o_ready = w_adv[0] & ~i_flush;
    assign o_valid = w_v[N-1];
    assign o_data  = w_d[N-1];
    assign w_up    = i_valid & o_ready;
    assign w_dn    = o_valid & i_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else if (w_up && !w_dn) begin
            r_count <= r_count + 1'b1;
        end else if (w_dn && !w_up) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;

    a_count_is_popcount: assert property (
        @(posedge clk) disable iff (!reset) r_count == CW'($countones(w_v))
    );

endmodule

// File: tb/tb_pipe_vec_elastic.sv
// Directed bench for pipe_vec_elastic with N=3 and payload reset enabled.
module tb_pipe_vec_elastic;

    localparam int DW = 8;
    localparam int N  = 3;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_flush = 1'b0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [DW-1:0] i_data = '0;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [DW-1:0] o_data;
    logic [CW-1:0] o_count;

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_d;

    pipe_vec_elastic #(
        .DWIDTH    (DW),
        .N         (N),
        .DataReset (1)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_count (o_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cycle(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", o_valid); end
        checks++; if (o_count !== 2'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", o_count); end
        checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h expected 00", o_data); end
        reset = 1'b1;
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", o_ready); end
        cycle();
    endtask

    task automatic test_back_to_back();
        i_ready = 1'b1;
        i_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_data = 8'(8'h11 * (i + 1));
            exp_q.push_back(i_data);
            #1;
            checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b expected 1", i, o_ready); end
            cycle();
        end
        i_valid = 1'b0;
        checks++; if (o_count !== 2'd3) begin errors++; $display("FAIL b2b_peak: got %0d expected 3", o_count); end
        for (int i = 0; i < 3; i++) begin
            exp_d = exp_q.pop_front();
            checks++; if (o_valid !== 1'b1 || o_data !== exp_d) begin errors++; $display("FAIL b2b_out%0d: got v=%b d=%h expected v=1 d=%h", i, o_valid, o_data, exp_d); end
            cycle();
        end
        checks++; if (o_valid !== 1'b0 || o_count !== 2'd0) begin errors++; $display("FAIL b2b_empty: got v=%b cnt=%0d expected v=0 cnt=0", o_valid, o_count); end
    endtask

    task automatic test_stall();
        i_ready = 1'b0;
        i_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_data = 8'(8'hA0 + i);
            #1;
            checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL stall_accept%0d: got %b expected 1", i, o_ready); end
            cycle();
        end
        i_data = 8'hA3;
        #1;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL stall_full_ready: got %b expected 0", o_ready); end
        checks++; if (o_count !== 2'd3) begin errors++; $display("FAIL stall_count: got %0d expected 3", o_count); end
        checks++; if (o_valid !== 1'b1 || o_data !== 8'hA0) begin errors++; $display("FAIL stall_head: got v=%b d=%h expected v=1 d=a0", o_valid, o_data); end
        cycle();
        checks++; if (o_data !== 8'hA0 || o_count !== 2'd3) begin errors++; $display("FAIL stall_hold: got d=%h cnt=%0d expected d=a0 cnt=3", o_data, o_count); end
        i_ready = 1'b1;
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b expected 1", o_ready); end
        cycle();
        i_ready = 1'b0;
        i_valid = 1'b0;
        #1;
        checks++; if (o_count !== 2'd3 || o_data !== 8'hA1) begin errors++; $display("FAIL stall_swap: got cnt=%0d d=%h expected cnt=3 d=a1", o_count, o_data); end
        exp_q = '{8'hA1, 8'hA2, 8'hA3};
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_d = exp_q.pop_front();
            checks++; if (o_valid !== 1'b1 || o_data !== exp_d) begin errors++; $display("FAIL stall_drain%0d: got v=%b d=%h expected v=1 d=%h", i, o_valid, o_data, exp_d); end
            cycle();
        end
        checks++; if (o_valid !== 1'b0 || o_count !== 2'd0) begin errors++; $display("FAIL stall_empty: got v=%b cnt=%0d expected v=0 cnt=0", o_valid, o_count); end
    endtask

    task automatic test_bubble();
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 8'h55;
        cycle();
        i_valid = 1'b0;
        cycle();
        i_valid = 1'b1;
        i_data  = 8'h66;
        cycle();
        i_valid = 1'b0;
        cycle();
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bubble_ready: got %b expected 1", o_ready); end
        checks++; if (o_count !== 2'd2) begin errors++; $display("FAIL bubble_count: got %0d expected 2", o_count); end
        checks++; if (o_valid !== 1'b1 || o_data !== 8'h55) begin errors++; $display("FAIL bubble_head: got v=%b d=%h expected v=1 d=55", o_valid, o_data); end
        i_ready = 1'b1;
        cycle();
        checks++; if (o_valid !== 1'b1 || o_data !== 8'h66) begin errors++; $display("FAIL bubble_packed: got v=%b d=%h expected v=1 d=66", o_valid, o_data); end
        cycle();
        checks++; if (o_valid !== 1'b0 || o_count !== 2'd0) begin errors++; $display("FAIL bubble_empty: got v=%b cnt=%0d expected v=0 cnt=0", o_valid, o_count); end
    endtask

    task automatic test_flush();
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 8'h01;
        cycle();
        i_data  = 8'h02;
        cycle();
        i_data  = 8'h77;
        i_flush = 1'b1;
        #1;
        checks++; if (o_count !== 2'd2) begin errors++; $display("FAIL flush_pre_count: got %0d expected 2", o_count); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", o_ready); end
        cycle();
        i_flush = 1'b0;
        i_valid = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0 || o_count !== 2'd0) begin errors++; $display("FAIL flush_cleared: got v=%b cnt=%0d expected v=0 cnt=0", o_valid, o_count); end
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'h78;
        cycle();
        i_valid = 1'b0;
        cycle();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_early: got %b expected 0", o_valid); end
        cycle();
        checks++; if (o_valid !== 1'b1 || o_data !== 8'h78) begin errors++; $display("FAIL flush_after: got v=%b d=%h expected v=1 d=78", o_valid, o_data); end
        cycle();
        checks++; if (o_count !== 2'd0) begin errors++; $display("FAIL flush_drained: got %0d expected 0", o_count); end
    endtask

    task automatic test_reset_mid();
        i_ready = 1'b0;
        i_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_data = 8'(8'hC1 + i);
            cycle();
        end
        i_valid = 1'b0;
        #1;
        checks++; if (o_count !== 2'd3) begin errors++; $display("FAIL rmid_full: got %0d expected 3", o_count); end
        reset = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0 || o_count !== 2'd0) begin errors++; $display("FAIL rmid_async: got v=%b cnt=%0d expected v=0 cnt=0", o_valid, o_count); end
        checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL rmid_data: got %h expected 00", o_data); end
        reset = 1'b1;
        cycle();
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'h99;
        cycle();
        i_valid = 1'b0;
        cycle(2);
        checks++; if (o_valid !== 1'b1 || o_data !== 8'h99) begin errors++; $display("FAIL rmid_traverse: got v=%b d=%h expected v=1 d=99", o_valid, o_data); end
        cycle();
        checks++; if (o_valid !== 1'b0 || o_count !== 2'd0) begin errors++; $display("FAIL rmid_empty: got v=%b cnt=%0d expected v=0 cnt=0", o_valid, o_count); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_bubble();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_vec_elastic.md
Name: pipe_vec_elastic

Overview:
- N-stage pipeline register with per-stage valid bits and valid/ready backpressure.
- Sits downstream of the fixed-latency pipe_vec delay lines, where a consumer (e.g. a memory/IO port) can stall.
- Empty stages collapse (bubble squashing), so an empty stage never blocks the stages behind it.
- Sustains 1 transfer/cycle with no stall; supports synchronous flush and reports occupancy.

Parameters:
- DWIDTH, 8: payload width in bits.
- N, 2: number of register stages; legal range 1..16.
- DataReset, 0: 1 = payload registers also cleared by reset; 0 = only valid bits are reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_flush  in  1  synchronous flush; clears all stages.
- i_valid  in  1  upstream payload valid.
- o_ready  out  1  upstream may transfer this cycle.
- i_data  in  DWIDTH  upstream payload.
- o_valid  out  1  downstream payload valid.
- i_ready  in  1  downstream accepts this cycle.
- o_data  out  DWIDTH  downstream payload, taken from stage N-1.
- o_count  out  $clog2(N+1)  number of valid stages.

Behaviour:
- State: v[k] and d[k] for k = 0..N-1. Stage 0 is the input side; stage N-1 is the output side.
- Advance chain (combinational):
  - adv[N] = i_ready.
  - adv[k] = !v[k] | adv[k+1].
- o_ready = adv[0] & !i_flush.
- o_valid = v[N-1]; o_data = d[N-1]; both outputs come straight from registers.
- Transfers:
  - Upstream transfer = i_valid & o_ready.
  - Downstream transfer = o_valid & i_ready.
- Per-stage update for k >= 1: when adv[k], v[k] <= v[k-1] & adv[k-1]'s source content and d[k] <= d[k-1].
  - Precisely: v[k] <= v[k-1], and d[k] <= d[k-1] only when v[k-1] = 1.
  - When adv[k] = 0, the stage holds.
- Stage 0 update: when adv[0], v[0] <= i_valid and d[0] <= i_data (only when i_valid = 1).
- Gating:
  - Payload registers load only when the source valid bit = 1, which cuts toggling.
  - Valid bits always follow the advance rules.
- Latency: with no stall, a word accepted at edge t appears on o_valid/o_data N cycles later.
- Throughput: 1 word/cycle in steady state with i_ready = 1.
- Stall: i_ready = 0 with v[N-1] = 1 holds stage N-1.
  - Upstream stages keep advancing into empty slots.
  - o_ready drops only when all N stages are valid.
- Stall release: when i_ready returns to 1 with all N stages full, o_ready = 1 in that same cycle. There is no dead cycle.
- Full and draining in the same cycle: upstream and downstream transfers happen together; o_count is unchanged.
- o_count:
  - Registered; reset value 0.
  - Updated as o_count + upstream transfer - downstream transfer.
  - Flush forces o_count to 0.
  - Must always equal the popcount of v; checked by assertion.
- Flush (i_flush = 1 at an edge):
  - All v[k] <= 0, o_count <= 0.
  - o_ready is 0 during the flush cycle, so no input is accepted.
  - A downstream transfer that cycle still completes: the consumer may sample o_data while i_ready = 1.
  - Flush has priority over every advance.
- Reset (reset = 0, asynchronous):
  - v[*] = 0, o_valid = 0, o_count = 0.
  - o_ready = 1 while reset is deasserted and i_flush = 0.
  - d[*] = 0 only if DataReset = 1; otherwise d[*] is undefined and o_data is don't-care while o_valid = 0.
- Reset mid-operation: all in-flight words are discarded immediately, with no partial output.
- Deassertion is synchronised externally; the block assumes reset release is clean relative to clk.
- Protocol rules:
  - Upstream must hold i_data stable while i_valid = 1 and o_ready = 0.
  - o_valid/o_data never change while o_valid = 1 and i_ready = 0, except on flush or reset.
- Combinational paths: i_ready -> o_ready passes through N AND/OR levels. This is accepted for N <= 16.

Decomposition:
- Shared package pipe_pkg holds:
  - localparam function cnt_w(n) = $clog2(n+1).
  - MAX_ELASTIC_DEPTH = 16.
  - No typedefs are needed; payload stays a flat logic vector.
- Natural sub-module elastic_stage: one valid+data register with inputs adv, src_valid, src_data and outputs valid, data.
- pipe_vec_elastic generates N instances of elastic_stage, plus the advance chain and the counter.

Test Plan:
- N=3, i_ready=1, push 0x11,0x22,0x33 on back-to-back cycles -> o_data 0x11,0x22,0x33 on cycles 3,4,5; o_ready stays 1; o_count peaks at 3.
- N=3, i_ready=0, push 0xA0..0xA3 -> 0xA0..0xA2 are accepted; o_ready=0 from the cycle after the 3rd accept; 0xA3 is held; o_count=3.
- From that full state, raise i_ready for 1 cycle -> 0xA0 transfers, 0xA3 is accepted in the same cycle, o_count stays 3, next o_data=0xA1.
- Bubble collapse, N=3:
  - Push 0x55, idle 1 cycle, push 0x66, with i_ready=0.
  - Expect both words packed into stages 2 and 1 with no bubble.
  - o_ready stays 1; o_count=2.
- Flush with 2 valid words and i_valid=1 (data 0x77) -> 0x77 is not accepted; next cycle o_valid=0, o_count=0; a push on the following cycle exits after N cycles.
- Assert reset low mid-stream with 3 valid words -> o_valid=0 and o_count=0 immediately, asynchronously; after release, 0x99 traverses with latency N; with DataReset=1, o_data=0x00 during reset.
